// File: rtl/heap_feeder.sv
// heap_feeder: upstream stage of the heap sorter.
//
// Accepts keys over a valid/ready handshake and tags each one with its arrival
// index. It paces heap insertions to at most one every other cycle, flushes the
// heap when the batch closes, and then counts returned words until the batch
// has drained. It reports completion, or a timeout if the heap goes quiet.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start        pulse, begins a batch (honoured only when idle)
//   s_valid      input key valid
//   s_ready      feeder accepts a key this cycle (decoded from state)
//   s_key        input key
//   end_batch    pulse, closes the batch early (honoured only while filling)
//   heap_din     word to heap, {arrival index zero-extended, key}
//   heap_en      heap insert strobe
//   heap_init    heap init strobe
//   heap_flush   heap flush strobe
//   heap_valid   heap output word valid (counted only while draining)
//   busy         feeder not idle (decoded from state)
//   batch_len    number of keys inserted in the current batch
//   done         one-cycle completion pulse
//   err          timeout flag, valid with done, held until the next start
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_INIT  | heap_init pulse, batch counters cleared
// S_FILL  | ready for a key, or end_batch
// S_GAP   | heap_en pulse for the captured key, never ready
// S_FLUSH | heap_flush pulse, drain counter and idle timer armed
// S_DRAIN | counting returned words, watching the idle timer
// S_DONE  | done pulse, err valid
module heap_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int KEY_WIDTH  = 8,
    parameter int NLEVELS    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [KEY_WIDTH-1:0]  s_key,
    input  logic                  end_batch,
    output logic [DATA_WIDTH-1:0] heap_din,
    output logic                  heap_en,
    output logic                  heap_init,
    output logic                  heap_flush,
    input  logic                  heap_valid,
    output logic                  busy,
    output logic [NLEVELS-1:0]    batch_len,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = DATA_WIDTH - KEY_WIDTH;
    localparam logic [NLEVELS-1:0] CAP = {NLEVELS{1'b1}};
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // DONE costs one cycle of its own, so the timer terminal count lands one
    // cycle early. done then appears exactly TIMEOUT cycles after the last activity.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FILL, S_GAP, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t state, next_state;

    logic               full;
    logic               closed;
    logic               hs;
    logic               idle_expired;
    logic [NLEVELS-1:0] drain_cnt;
    logic [TMR_W-1:0]   idle_tmr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        s_ready      = 1'b0;
        busy         = (state != S_IDLE);
        hs           = 1'b0;
        idle_expired = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_INIT;
            end
            S_INIT: begin
                next_state = S_FILL;
            end
            S_FILL: begin
                s_ready = 1'b1;
                hs      = s_valid;
                // A key arriving together with end_batch is still accepted.
                if (s_valid) begin
                    next_state = S_GAP;
                end else if (end_batch) begin
                    next_state = (batch_len == '0) ? S_DONE : S_FLUSH;
                end
            end
            S_GAP: begin
                next_state = (full || closed) ? S_FLUSH : S_FILL;
            end
            S_FLUSH: begin
                next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (heap_valid) begin
                    if ((drain_cnt + NLEVELS'(1)) == batch_len) next_state = S_DONE;
                end else if (idle_tmr == '0) begin
                    idle_expired = 1'b1;
                    next_state   = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from next_state so that each one is high during
    // the matching state cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            heap_din   <= '0;
            heap_en    <= 1'b0;
            heap_init  <= 1'b0;
            heap_flush <= 1'b0;
            batch_len  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            full       <= 1'b0;
            closed     <= 1'b0;
            drain_cnt  <= '0;
            idle_tmr   <= '0;
        end else begin
            heap_init  <= (next_state == S_INIT);
            heap_en    <= (next_state == S_GAP);
            heap_flush <= (next_state == S_FLUSH);
            done       <= (next_state == S_DONE);

            if (state == S_IDLE && start) err <= 1'b0;
            if (idle_expired)             err <= 1'b1;

            case (state)
                S_INIT: begin
                    batch_len <= '0;
                    full      <= 1'b0;
                    closed    <= 1'b0;
                end
                S_FILL: begin
                    if (hs) begin
                        heap_din  <= {IDX_W'(batch_len), s_key};
                        batch_len <= batch_len + NLEVELS'(1);
                        full      <= ((batch_len + NLEVELS'(1)) == CAP);
                        closed    <= end_batch;
                    end
                end
                S_FLUSH: begin
                    drain_cnt <= '0;
                    idle_tmr  <= TMR_LOAD;
                end
                S_DRAIN: begin
                    if (heap_valid) begin
                        drain_cnt <= drain_cnt + NLEVELS'(1);
                        idle_tmr  <= TMR_LOAD;
                    end else if (idle_tmr != '0) begin
                        idle_tmr <= idle_tmr - TMR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heap_feeder.sv
// Self-checking bench for heap_feeder. A negedge monitor logs every heap_en
// word, flush, init and done. Each batch is then compared against the keys it
// was fed and against the expected pacing and latencies.
module tb_heap_feeder;

    localparam int DW  = 16;
    localparam int KW  = 8;
    localparam int NL  = 4;
    localparam int TO  = 64;
    localparam int CAP = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          end_batch = 1'b0;
    logic          heap_valid = 1'b0;
    logic [KW-1:0] s_key = '0;
    logic          s_ready, heap_en, heap_init, heap_flush, busy, done, err;
    logic [DW-1:0] heap_din;
    logic [NL-1:0] batch_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    heap_feeder #(
        .DATA_WIDTH(DW), .KEY_WIDTH(KW), .NLEVELS(NL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_key(s_key), .end_batch(end_batch), .heap_din(heap_din), .heap_en(heap_en),
        .heap_init(heap_init), .heap_flush(heap_flush), .heap_valid(heap_valid),
        .busy(busy), .batch_len(batch_len), .done(done), .err(err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] words[$];
    int            en_cyc[$];
    int            flush_cnt = 0, flush_cyc = 0, done_cnt = 0, done_cyc = 0;
    int            init_cnt = 0, b2b = 0;
    logic          done_err = 1'b0, prev_en = 1'b0;

    always @(negedge clk) begin
        if (heap_en) begin
            words.push_back(heap_din);
            en_cyc.push_back(cyc);
            if (prev_en) b2b++;
        end
        prev_en = heap_en;
        if (heap_flush) begin
            flush_cnt++;
            flush_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        if (heap_init) init_cnt++;
    end

    logic [KW-1:0] keys[CAP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: fill to capacity, 1: end_batch alone after the last key,
    // 2: end_batch together with the last key.
    task automatic run_batch(input int n, input int mode, input int max_gap, input int n_ret,
                             input int ret_min, input int ret_max, input bit poke_start);
        int            w0, f0, d0, ic, waits, gap, end_cyc, last_act;
        int            hs_cyc[CAP];
        logic [DW-1:0] exp_word;
        w0      = words.size();
        f0      = flush_cnt;
        d0      = done_cnt;
        end_cyc = 0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("init_lat", heap_init, 1);
        check("err_clr", err, 0);
        tick();

        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(max_gap, 0);
            repeat (gap) tick();
            s_valid   = 1'b1;
            s_key     = keys[i];
            end_batch = (mode == 2 && i == n - 1);
            waits = 0;
            while (!s_ready && waits < 8) begin
                tick();
                waits++;
            end
            check("rdy_wait", waits, (i > 0 && gap == 0) ? 1 : 0);
            hs_cyc[i] = cyc;
            tick();
            s_valid   = 1'b0;
            end_batch = 1'b0;
        end

        if (mode == 1) begin
            waits = 0;
            while (!s_ready && waits < 8) begin
                tick();
                waits++;
            end
            end_batch = 1'b1;
            end_cyc   = cyc;
            tick();
            end_batch = 1'b0;
        end

        if (n == 0) begin
            check("empty_done", done, 1);
            tick();
            check("empty_busy", busy, 0);
            check("empty_len", batch_len, 0);
            check("empty_noflush", flush_cnt - f0, 0);
            return;
        end

        waits = 0;
        while (flush_cnt == f0 && waits < 10) begin
            tick();
            waits++;
        end
        check("flush_seen", flush_cnt - f0, 1);
        if (mode == 1)
            check("flush_lat", flush_cyc, end_cyc + 1);
        else if (en_cyc.size() > 0)
            check("flush_lat", flush_cyc, en_cyc[en_cyc.size() - 1] + 1);
        check("n_words", words.size() - w0, n);
        for (int i = 0; i < n; i++) begin
            if (w0 + i < words.size()) begin
                exp_word = {(DW - KW)'(i), keys[i]};
                check("word", words[w0 + i], exp_word);
                check("en_lat", en_cyc[w0 + i], hs_cyc[i] + 1);
            end
        end
        check("en_b2b", b2b, 0);
        check("batch_len", batch_len, n);
        check("rdy_drain", s_ready, 0);

        last_act = flush_cyc;
        ic = init_cnt;
        for (int j = 0; j < n_ret; j++) begin
            repeat ($urandom_range(ret_max, ret_min)) tick();
            heap_valid = 1'b1;
            if (poke_start && j == 0) start = 1'b1;
            last_act = cyc;
            tick();
            heap_valid = 1'b0;
            start      = 1'b0;
        end

        waits = 0;
        while (done_cnt == d0 && waits < TO + 20) begin
            tick();
            waits++;
        end
        check("done_seen", done_cnt - d0, 1);
        check("done_lat", done_cyc, (n_ret >= n) ? last_act + 1 : last_act + TO);
        check("done_err", done_err, (n_ret < n) ? 1 : 0);
        tick();
        check("busy_end", busy, 0);
        check("len_hold", batch_len, n);
        check("err_hold", err, (n_ret < n) ? 1 : 0);
        check("one_flush", flush_cnt - f0, 1);
        if (poke_start) check("start_ignored", init_cnt, ic);
    endtask

    initial begin
        int n, mode, f0;

        repeat (3) tick();
        check("rst_din", heap_din, 0);
        check("rst_len", batch_len, 0);
        check("rst_strobes", {heap_en, heap_init, heap_flush, done}, 0);
        check("rst_flags", {busy, s_ready, err}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < CAP; i++) keys[i] = 8'(200 - i);
        run_batch(CAP, 0, 0, CAP, 2, 2, 1'b0);
        if (words.size() > 2) check("word3", words[2], 16'h02C6);

        keys[0] = 8'd5; keys[1] = 8'd9; keys[2] = 8'd1;
        run_batch(3, 1, 0, 3, 0, 4, 1'b0);

        for (int i = 0; i < CAP; i++) keys[i] = 8'($urandom);
        run_batch(2, 2, 0, 2, 0, 3, 1'b0);

        run_batch(0, 1, 0, 0, 0, 0, 1'b0);

        repeat (8) begin
            n    = $urandom_range(CAP, 1);
            mode = (n == CAP) ? 0 : $urandom_range(2, 1);
            for (int i = 0; i < CAP; i++) keys[i] = 8'($urandom);
            run_batch(n, mode, 2, n, 0, 5, 1'b0);
        end

        for (int i = 0; i < CAP; i++) keys[i] = 8'($urandom);
        run_batch(4, 1, 1, 2, 0, 3, 1'b1);
        check("err_idle_hold", err, 1);

        // Reset in the middle of a fill.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        f0      = flush_cnt;
        s_valid = 1'b1;
        s_key   = 8'h33;
        tick();
        s_valid = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("mid_rst_din", heap_din, 0);
        check("mid_rst_len", batch_len, 0);
        check("mid_rst_strobes", {heap_en, heap_init, heap_flush, done}, 0);
        check("mid_rst_flags", {busy, s_ready, err}, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("mid_rst_noflush", flush_cnt - f0, 0);
        for (int i = 0; i < CAP; i++) keys[i] = 8'($urandom);
        run_batch(3, 1, 1, 3, 0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
